key_debounce_bank: RTL and testbench

Parametrised multi-channel push-button debouncer. It generalises the team's single-key 4-state debouncer to CH independent channels, each with a 2-flop input synchroniser and a configurable stability interval. Each channel also produces registered one-cycle press/release event pulses. It sits between the board button pins and the pong game logic (paddle up/down, start/reset buttons), so game logic consumes clean levels or single-cycle events.

---
 rtl/key_debounce_bank_if.sv | 29 ++
 rtl/key_debounce_bank.sv | 130 +++++++++++++
 tb/tb_key_debounce_bank.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_debounce_bank_if.sv
// Purpose : key pin / debounced level / event bundle for key_debounce_bank.
// Ports   : key_in (raw pins), key_out (clean levels), key_rise/key_fall
//           (one-cycle events per channel), key_any (OR of all events, delayed).
// Modports: master drives key_in and observes the rest; slave is the debouncer.
interface key_debounce_bank_if #(
  parameter int CH = 4
);
  logic [CH-1:0] key_in;
  logic [CH-1:0] key_out;
  logic [CH-1:0] key_rise;
  logic [CH-1:0] key_fall;
  logic          key_any;

  modport master (
    output key_in,
    input  key_out,
    input  key_rise,
    input  key_fall,
    input  key_any
  );

  modport slave (
    input  key_in,
    output key_out,
    output key_rise,
    output key_fall,
    output key_any
  );
endinterface

// File: rtl/key_debounce_bank.sv
// Purpose : CH independent push-button debouncers with press/release events.
// Latency : key_out/key_rise/key_fall change DELAY+3 cycles after key_in; key_any one later.
// Backpr. : none; events are single-cycle pulses, never stretched or queued.
// Ports   : clk, rst (async, active-high), bus (slave modport): key_in in,
//           key_out/key_rise/key_fall/key_any out.
module key_debounce_bank #(
  parameter int   CH       = 4,
  parameter int   DELAY    = 5000000,
  parameter int   CNT_W    = 23,
  parameter logic INIT_LVL = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  key_debounce_bank_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_LO = 2'd0,
    LO2HI = 2'd1,
    ST_HI = 2'd2,
    HI2LO = 2'd3
  } state_t;

  localparam state_t          ST_INIT  = INIT_LVL ? ST_HI : ST_LO;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY - 1);

  logic [CH-1:0]    s1;
  logic [CH-1:0]    s2;
  state_t           state     [CH];
  state_t           state_nxt [CH];
  logic [CNT_W-1:0] cnt       [CH];
  logic [CNT_W-1:0] cnt_nxt   [CH];
  logic [CH-1:0]    out_nxt;
  logic [CH-1:0]    rise_nxt;
  logic [CH-1:0]    fall_nxt;

  // Two-flop synchroniser; everything downstream looks at s2 only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= {CH{INIT_LVL}};
      s2 <= {CH{INIT_LVL}};
    end else begin
      s1 <= bus.key_in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        state[i] <= ST_INIT;
        cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
    end
  end

  // A reversal of s2 in a transition state returns to the old stable state,
  // so the next attempt starts counting from zero again.
  always_comb begin
    out_nxt  = '0;
    rise_nxt = '0;
    fall_nxt = '0;
    for (int i = 0; i < CH; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      case (state[i])
        ST_LO: begin
          if (s2[i]) begin
            state_nxt[i] = LO2HI;
            cnt_nxt[i]   = '0;
          end
        end
        LO2HI: begin
          if (!s2[i]) begin
            state_nxt[i] = ST_LO;
          end else if (cnt[i] == CNT_LAST) begin
            state_nxt[i] = ST_HI;
            rise_nxt[i]  = 1'b1;
          end else begin
            cnt_nxt[i] = cnt[i] + CNT_W'(1);
          end
        end
        ST_HI: begin
          if (!s2[i]) begin
            state_nxt[i] = HI2LO;
            cnt_nxt[i]   = '0;
          end
        end
        HI2LO: begin
          if (s2[i]) begin
            state_nxt[i] = ST_HI;
          end else if (cnt[i] == CNT_LAST) begin
            state_nxt[i] = ST_LO;
            fall_nxt[i]  = 1'b1;
          end else begin
            cnt_nxt[i] = cnt[i] + CNT_W'(1);
          end
        end
        default: begin
          state_nxt[i] = ST_INIT;
          cnt_nxt[i]   = '0;
        end
      endcase
      // Level follows the stable side of the FSM: old level held while pending.
      out_nxt[i] = (state_nxt[i] == ST_HI) || (state_nxt[i] == HI2LO);
    end
  end

  // Outputs are registered alongside the state so key_out and the event pulse
  // change on the same edge; key_any is a further register stage on top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.key_out  <= {CH{INIT_LVL}};
      bus.key_rise <= '0;
      bus.key_fall <= '0;
      bus.key_any  <= 1'b0;
    end else begin
      bus.key_out  <= out_nxt;
      bus.key_rise <= rise_nxt;
      bus.key_fall <= fall_nxt;
      bus.key_any  <= |(bus.key_rise | bus.key_fall);
    end
  end

endmodule

// File: tb/tb_key_debounce_bank.sv
// Purpose : randomized + directed check of key_debounce_bank against a
//           run-length reference model, in two configurations (DELAY=8, DELAY=1).
// Ports   : none (top-level bench).
module tb_key_debounce_bank;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_debounce_bank_if #(.CH(4)) ifa ();
  key_debounce_bank_if #(.CH(2)) ifb ();

  key_debounce_bank #(.CH(4), .DELAY(8), .CNT_W(4), .INIT_LVL(1'b1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  key_debounce_bank #(.CH(2), .DELAY(1), .CNT_W(1), .INIT_LVL(1'b1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  typedef struct packed {
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       any;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: a channel accepts a new level once the synchronised pin
  // (the pin as it was two edges ago) has differed from the accepted level on
  // DELAY+1 consecutive edges; any agreeing sample restarts the count.
  int         dly  [2] = '{8, 1};
  logic [3:0] h0   [2];
  logic [3:0] h1   [2];
  logic [3:0] lvl  [2];
  logic [3:0] prs  [2];
  logic [3:0] pfl  [2];
  logic       pany [2];
  int         run  [2][4];

  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      logic [3:0] kin;
      logic [3:0] s2v;
      logic [3:0] nr;
      logic [3:0] nf;
      logic       na;
      exp_t       e;
      kin = (b == 0) ? ifa.key_in : {2'b11, ifb.key_in};
      if (rst) begin
        h0[b] = 4'hF; h1[b] = 4'hF; lvl[b] = 4'hF;
        prs[b] = 4'h0; pfl[b] = 4'h0; pany[b] = 1'b0;
        for (int c = 0; c < 4; c++) run[b][c] = 0;
      end else begin
        na  = |(prs[b] | pfl[b]);
        nr  = 4'h0;
        nf  = 4'h0;
        s2v = h1[b];
        h1[b] = h0[b];
        h0[b] = kin;
        for (int c = 0; c < 4; c++) begin
          if (s2v[c] != lvl[b][c]) begin
            run[b][c]++;
            if (run[b][c] == dly[b] + 1) begin
              lvl[b][c] = s2v[c];
              run[b][c] = 0;
              if (s2v[c]) nr[c] = 1'b1;
              else        nf[c] = 1'b1;
            end
          end else begin
            run[b][c] = 0;
          end
        end
        prs[b] = nr; pfl[b] = nf; pany[b] = na;
      end
      e.out = lvl[b]; e.rise = prs[b]; e.fall = pfl[b]; e.any = pany[b];
      if (b == 0) q_a.push_back(e);
      else        q_b.push_back(e);
    end
  end

  // Monitor: the outputs are presented every cycle, so one expectation per edge.
  always @(negedge clk) begin
    exp_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      check("a_key_out",  ifa.key_out,  e.out);
      check("a_key_rise", ifa.key_rise, e.rise);
      check("a_key_fall", ifa.key_fall, e.fall);
      check("a_key_any",  {3'b0, ifa.key_any}, {3'b0, e.any});
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      check("b_key_out",  {2'b0, ifb.key_out},  {2'b0, e.out[1:0]});
      check("b_key_rise", {2'b0, ifb.key_rise}, {2'b0, e.rise[1:0]});
      check("b_key_fall", {2'b0, ifb.key_fall}, {2'b0, e.fall[1:0]});
      check("b_key_any",  {3'b0, ifb.key_any},  {3'b0, e.any});
    end
  end

  // Inputs change just after a falling edge, well away from the rising edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Counts rising edges until the selected condition is seen (sampled at negedge).
  task automatic measure(input string name, input int sel, input int bound, input int want);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    while (!done && n < bound) begin
      @(negedge clk);
      n++;
      case (sel)
        0:       done = (ifa.key_out[0] == 1'b0);
        1:       done = (ifa.key_fall != 4'h0);
        2:       done = (ifa.key_rise != 4'h0);
        default: done = (ifb.key_out[0] == 1'b0);
      endcase
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout after %0d edges, expected event at edge %0d", name, n, want);
    end else begin
      check_int(name, n, want);
    end
  endtask

  int falls3;

  initial begin
    rst        = 1'b1;
    ifa.key_in = 4'hF;
    ifb.key_in = 2'b11;
    step(3);
    check("rst_key_out",  ifa.key_out,  4'hF);
    check("rst_key_rise", ifa.key_rise, 4'h0);
    check("rst_key_fall", ifa.key_fall, 4'h0);
    check("rst_key_any",  {3'b0, ifa.key_any}, 4'h0);
    rst = 1'b0;
    step(4);

    // Reset in the middle of a pending release: the change is dropped.
    ifa.key_in[3] = 1'b0;
    step(6);
    rst = 1'b1;
    ifa.key_in[3] = 1'b1;
    step(2);
    rst = 1'b0;
    falls3 = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ifa.key_fall[3]) falls3++;
    end
    check_int("rst_mid_no_pulse", falls3, 0);
    check("rst_mid_key_out", ifa.key_out, 4'hF);
    step(1);

    // Clean press on channel 0.
    ifa.key_in[0] = 1'b0;
    measure("press_latency", 0, 40, 11);
    check("press_fall", ifa.key_fall, 4'b0001);
    @(negedge clk);
    check("press_fall_clear", ifa.key_fall, 4'h0);
    check("press_any", {3'b0, ifa.key_any}, 4'h1);
    step(1);
    ifa.key_in[0] = 1'b1;
    step(16);

    // Bounce on channel 1, then settle low.
    for (int k = 0; k < 10; k++) begin
      ifa.key_in[1] = (k % 2 == 0) ? 1'b0 : 1'b1;
      step(3);
    end
    ifa.key_in[1] = 1'b0;
    step(20);
    check("bounce_settled", ifa.key_out, 4'hD);
    ifa.key_in[1] = 1'b1;
    step(16);

    // Short glitch on channel 2.
    ifa.key_in[2] = 1'b0;
    step(7);
    ifa.key_in[2] = 1'b1;
    step(16);
    check("glitch_key_out", ifa.key_out, 4'hF);

    // All channels together.
    ifa.key_in = 4'h0;
    measure("sim_fall_latency", 1, 40, 11);
    check("sim_fall_all", ifa.key_fall, 4'hF);
    @(negedge clk);
    check("sim_fall_once", ifa.key_fall, 4'h0);
    check("sim_any_hi", {3'b0, ifa.key_any}, 4'h1);
    @(negedge clk);
    check("sim_any_lo", {3'b0, ifa.key_any}, 4'h0);
    step(1);
    ifa.key_in = 4'hF;
    measure("sim_rise_latency", 2, 40, 11);
    check("sim_rise_all", ifa.key_rise, 4'hF);
    step(6);

    // DELAY=1 bank: press accepted at edge 4, then short low pulses.
    ifb.key_in[0] = 1'b0;
    measure("d1_press_latency", 3, 20, 4);
    step(1);
    ifb.key_in[0] = 1'b1;
    step(8);
    ifb.key_in[1] = 1'b0;
    step(1);
    ifb.key_in[1] = 1'b1;
    step(8);
    ifb.key_in[1] = 1'b0;
    step(2);
    ifb.key_in[1] = 1'b1;
    step(8);

    // Random phase with alternating busy/quiet segments and one reset.
    for (int k = 0; k < 1600; k++) begin
      int j;
      int lim;
      step(1);
      lim = ((k / 200) % 2 == 0) ? 24 : 3;
      if ($urandom_range(0, lim) == 0) begin
        j = $urandom_range(0, 3);
        ifa.key_in[j] = ~ifa.key_in[j];
      end
      if ($urandom_range(0, 3) == 0) begin
        j = $urandom_range(0, 1);
        ifb.key_in[j] = ~ifb.key_in[j];
      end
      if (k == 900) rst = 1'b1;
      if (k == 902) rst = 1'b0;
    end
    step(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
